// File: rtl/man2_sprite_render.sv
// Player-2 sprite stage: holds and glides the on-screen position, tests each pixel for a sprite hit, composites over background.
// Latency: mask_px/mask_py combinational from px/py; pix_col/pix_hit registered (1 cycle); position updates only on frame_start.
// Backpressure: none; the stage accepts one pixel every clock and the game logic re-presents its target until it is taken.
//
// Ports:
//   clk, rst_n           pixel clock, synchronous active-low reset
//   frame_start          1-cycle pulse at start of vertical blank (position update strobe)
//   tgt_col, tgt_row     requested grid cell from game logic
//   alive                0 hides the sprite and freezes the glide
//   px, py, video_on     current VGA pixel and visibility
//   bg_col               background colour for this pixel
//   mask_col / mask_px, mask_py   colour ROM return / sprite-local coordinates sent to it
//   pix_col, pix_hit     registered composited colour and sprite-hit flag
//   moving               high while a glide is in progress
module man2_sprite_render #(
    parameter int TILE     = 16,
    parameter int STEP     = 2,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int GRID_W   = 15,
    parameter int GRID_H   = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [4:0] tgt_col,
    input  logic [4:0] tgt_row,
    input  logic       alive,
    input  logic [9:0] px,
    input  logic [9:0] py,
    input  logic       video_on,
    input  logic [2:0] bg_col,
    input  logic [2:0] mask_col,
    output logic [9:0] mask_px,
    output logic [9:0] mask_py,
    output logic [2:0] pix_col,
    output logic       pix_hit,
    output logic       moving
);

    typedef enum logic {IDLE, MOVE} state_t;

    state_t     state, state_nx;
    logic [9:0] cur_x, cur_y, cur_x_nx, cur_y_nx;
    logic [4:0] cur_col, cur_row, cur_col_nx, cur_row_nx;
    logic [4:0] goal_col, goal_row, goal_col_nx, goal_row_nx;
    logic [9:0] goal_x, goal_y;
    logic       tgt_valid;
    logic       hit, pix_hit_nx;
    logic [2:0] pix_col_nx;
    logic [10:0] x_end, y_end;

    // One glide step toward goal, clamped so it never overshoots.
    function automatic logic [9:0] step_to(input logic [9:0] cur, input logic [9:0] goal);
        if (cur < goal)
            return ((goal - cur) > 10'(STEP)) ? cur + 10'(STEP) : goal;
        else if (cur > goal)
            return ((cur - goal) > 10'(STEP)) ? cur - 10'(STEP) : goal;
        else
            return cur;
    endfunction

    assign goal_x    = 10'(ORIGIN_X) + 10'(goal_col) * 10'(TILE);
    assign goal_y    = 10'(ORIGIN_Y) + 10'(goal_row) * 10'(TILE);
    assign tgt_valid = alive && (tgt_col < 5'(GRID_W)) && (tgt_row < 5'(GRID_H));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_x    <= 10'(ORIGIN_X);
            cur_y    <= 10'(ORIGIN_Y);
            cur_col  <= 5'd0;
            cur_row  <= 5'd0;
            goal_col <= 5'd0;
            goal_row <= 5'd0;
        end else begin
            state    <= state_nx;
            cur_x    <= cur_x_nx;
            cur_y    <= cur_y_nx;
            cur_col  <= cur_col_nx;
            cur_row  <= cur_row_nx;
            goal_col <= goal_col_nx;
            goal_row <= goal_row_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cur_x_nx    = cur_x;
        cur_y_nx    = cur_y;
        cur_col_nx  = cur_col;
        cur_row_nx  = cur_row;
        goal_col_nx = goal_col;
        goal_row_nx = goal_row;
        case (state)
            IDLE: begin
                if (frame_start && tgt_valid && ((tgt_col != cur_col) || (tgt_row != cur_row))) begin
                    goal_col_nx = tgt_col;
                    goal_row_nx = tgt_row;
                    state_nx    = MOVE;
                end
            end
            MOVE: begin
                // x axis first, then y; a dead player simply stalls the glide.
                if (frame_start && alive) begin
                    if (cur_x != goal_x)
                        cur_x_nx = step_to(cur_x, goal_x);
                    else
                        cur_y_nx = step_to(cur_y, goal_y);
                    if ((cur_x_nx == goal_x) && (cur_y_nx == goal_y)) begin
                        state_nx   = IDLE;
                        cur_col_nx = goal_col;
                        cur_row_nx = goal_row;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign moving = (state == MOVE);

    // Pixel path. Bounds use 11-bit sums so a sprite near x=1023 cannot wrap.
    assign mask_px = px - cur_x;
    assign mask_py = py - cur_y;
    assign x_end   = {1'b0, cur_x} + 11'(TILE);
    assign y_end   = {1'b0, cur_y} + 11'(TILE);
    assign hit     = video_on && alive
                     && (px >= cur_x) && ({1'b0, px} < x_end)
                     && (py >= cur_y) && ({1'b0, py} < y_end);
    assign pix_hit_nx = hit && (mask_col != 3'b000);
    assign pix_col_nx = !video_on ? 3'b000 : (pix_hit_nx ? mask_col : bg_col);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_col <= 3'b000;
            pix_hit <= 1'b0;
        end else begin
            pix_col <= pix_col_nx;
            pix_hit <= pix_hit_nx;
        end
    end

endmodule
